// File: rtl/bcd_operand_entry.sv
// Operand entry for a two-digit BCD adder: debounced Enter captures A1, A0, B1, B0 in turn.
// Clear aborts the entry; Valid marks a complete operand set.
module bcd_operand_entry #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] digit,
    input  logic       enter,
    input  logic       clear,
    output logic [3:0] a1,
    output logic [3:0] a0,
    output logic [3:0] b1,
    output logic [3:0] b0,
    output logic       valid,
    output logic       error,
    output logic [2:0] state
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        StGetA1 = 3'd0,
        StGetA0 = 3'd1,
        StGetB1 = 3'd2,
        StGetB0 = 3'd3,
        StDone  = 3'd4
    } state_e;

    logic [SYNC_STAGES-1:0] enter_sync, clear_sync;
    logic                   enter_s, clear_s;
    logic [CntW-1:0]        hi_cnt, lo_cnt;
    logic                   armed, press_q;

    state_e     state_q, state_d;
    logic [3:0] a1_q, a1_d, a0_q, a0_d, b1_q, b1_d, b0_q, b0_d;
    logic       error_q, error_d, valid_q, valid_d;
    logic       digit_ok;

    assign enter_s  = enter_sync[SYNC_STAGES-1];
    assign clear_s  = clear_sync[SYNC_STAGES-1];
    assign digit_ok = (digit <= 4'd9);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enter_sync <= '0;
            clear_sync <= '0;
        end else begin
            enter_sync <= {enter_sync[SYNC_STAGES-2:0], enter};
            clear_sync <= {clear_sync[SYNC_STAGES-2:0], clear};
        end
    end

    // One-cycle press when the high run reaches the limit; re-armed only by a full low run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_cnt  <= '0;
            lo_cnt  <= '0;
            armed   <= 1'b1;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (enter_s) begin
                lo_cnt <= '0;
                if (hi_cnt != CntMax) hi_cnt <= hi_cnt + CntW'(1);
                if (hi_cnt == CntLast && armed) begin
                    press_q <= 1'b1;
                    armed   <= 1'b0;
                end
            end else begin
                hi_cnt <= '0;
                if (lo_cnt != CntMax) lo_cnt <= lo_cnt + CntW'(1);
                if (lo_cnt == CntLast) armed <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a1_d    = a1_q;
        a0_d    = a0_q;
        b1_d    = b1_q;
        b0_d    = b0_q;
        error_d = error_q;
        if (clear_s) begin
            state_d = StGetA1;
            a1_d    = 4'd0;
            a0_d    = 4'd0;
            b1_d    = 4'd0;
            b0_d    = 4'd0;
            error_d = 1'b0;
        end else begin
            unique case (state_q)
                StGetA1, StGetA0, StGetB1, StGetB0: begin
                    if (press_q) begin
                        error_d = !digit_ok;
                        if (digit_ok) begin
                            unique case (state_q)
                                StGetA1: begin a1_d = digit; state_d = StGetA0; end
                                StGetA0: begin a0_d = digit; state_d = StGetB1; end
                                StGetB1: begin b1_d = digit; state_d = StGetB0; end
                                default: begin b0_d = digit; state_d = StDone;  end
                            endcase
                        end
                    end
                end
                StDone: begin
                    if (press_q) begin
                        state_d = StGetA1;
                        a1_d    = 4'd0;
                        a0_d    = 4'd0;
                        b1_d    = 4'd0;
                        b0_d    = 4'd0;
                        error_d = 1'b0;
                    end
                end
                default: state_d = StGetA1;
            endcase
        end
        valid_d = (state_d == StDone);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StGetA1;
            a1_q    <= 4'd0;
            a0_q    <= 4'd0;
            b1_q    <= 4'd0;
            b0_q    <= 4'd0;
            error_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a1_q    <= a1_d;
            a0_q    <= a0_d;
            b1_q    <= b1_d;
            b0_q    <= b0_d;
            error_q <= error_d;
            valid_q <= valid_d;
        end
    end

    assign a1    = a1_q;
    assign a0    = a0_q;
    assign b1    = b1_q;
    assign b0    = b0_q;
    assign valid = valid_q;
    assign error = error_q;
    assign state = state_q;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Self-checking bench for bcd_operand_entry with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Expected values come from an entry-sequence model: a list of captured digits plus an error flag.
module tb_bcd_operand_entry;

    logic       clock, reset, enter, clear;
    logic [3:0] digit;
    logic [3:0] a1, a0, b1, b0;
    logic       valid, error;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Model: digits captured so far (count 0..4 doubles as the state code).
    int m_dig[4];
    int m_cnt;
    int m_err;

    bcd_operand_entry #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .digit(digit),
        .enter(enter),
        .clear(clear),
        .a1   (a1),
        .a0   (a0),
        .b1   (b1),
        .b0   (b0),
        .valid(valid),
        .error(error),
        .state(state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_cnt = 0;
        m_err = 0;
    endfunction

    function automatic void model_press(input int d);
        if (m_cnt == 4) begin
            model_clear();
        end else if (d <= 9) begin
            m_dig[m_cnt] = d;
            m_cnt++;
            m_err = 0;
        end else begin
            m_err = 1;
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_a1"}, 32'(a1), 32'(m_dig[0]));
        chk({tag, "_a0"}, 32'(a0), 32'(m_dig[1]));
        chk({tag, "_b1"}, 32'(b1), 32'(m_dig[2]));
        chk({tag, "_b0"}, 32'(b0), 32'(m_dig[3]));
        chk({tag, "_state"}, 32'(state), 32'(m_cnt));
        chk({tag, "_valid"}, 32'(valid), 32'(m_cnt == 4));
        chk({tag, "_error"}, 32'(error), 32'(m_err));
    endtask

    // Clean press: nothing may change before edge 7, then exactly one update; Digit only
    // matters at the consuming edge.
    task automatic press_digit(input int d, input string tag);
        digit = 4'($urandom_range(0, 15));
        enter = 1'b1;
        repeat (5) tick();
        digit = 4'(d);
        tick();
        chk({tag, "_hold_state"}, 32'(state), 32'(m_cnt));
        chk({tag, "_hold_error"}, 32'(error), 32'(m_err));
        tick();
        model_press(d);
        check_all(tag);
        digit = 4'($urandom_range(0, 15));
        enter = 1'b0;
        repeat (8) tick();
        check_all({tag, "_after"});
    endtask

    task automatic do_clear(input string tag);
        clear = 1'b1;
        repeat (3) tick();
        model_clear();
        check_all(tag);
        clear = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        enter = 1'b0;
        clear = 1'b0;
        digit = 4'd0;
        model_clear();
        repeat (2) tick();
        check_all("reset");
        reset = 1'b0;
        tick();

        press_digit(7, "full_a1");
        press_digit(3, "full_a0");
        press_digit(5, "full_b1");
        press_digit(9, "full_b0");

        press_digit(1, "done_press");

        // Bounce: 3 high, 1 low, 6 high must give a single press.
        digit = 4'd6;
        enter = 1'b1;
        repeat (3) tick();
        enter = 1'b0;
        tick();
        enter = 1'b1;
        repeat (6) tick();
        enter = 1'b0;
        repeat (10) tick();
        model_press(6);
        check_all("bounce");

        press_digit(12, "bad_digit");
        press_digit(4, "follow_on");

        do_clear("clear_plain");
        press_digit(2, "pre_clr_a1");
        press_digit(8, "pre_clr_a0");

        // Clear reaches the FSM on the same edge as the press event.
        digit = 4'd9;
        enter = 1'b1;
        repeat (4) tick();
        clear = 1'b1;
        repeat (3) tick();
        model_clear();
        check_all("clr_prio");
        clear = 1'b0;
        enter = 1'b0;
        repeat (10) tick();
        check_all("clr_prio_after");

        press_digit(3, "pre_rst");

        // Reset mid-debounce, Enter kept high through and after it.
        digit = 4'd5;
        enter = 1'b1;
        repeat (4) tick();
        #2 reset = 1'b1;
        #1;
        model_clear();
        check_all("rst_async");
        #1 reset = 1'b0;
        repeat (6) tick();
        chk("rst_hold_state", 32'(state), 32'd0);
        chk("rst_hold_a1", 32'(a1), 32'd0);
        tick();
        model_press(5);
        check_all("rst_capture");
        enter = 1'b0;
        repeat (8) tick();

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 9) == 0) do_clear("rnd_clear");
            else press_digit(int'($urandom_range(0, 15)), "rnd_press");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
